// File: rtl/fifo_ctrl.sv
// FIFO control: strobes, binary addresses, occupancy and sticky error flags.
// The memory stage owns the data and its timing; this block only steers it.
module fifo_ctrl #(
  parameter int a_heigth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_req,
  input  logic                     rd_req,
  output logic                     write,
  output logic                     read,
  output logic [(1<<a_heigth)-1:0] write_pointer,
  output logic [(1<<a_heigth)-1:0] read_pointer,
  output logic                     full,
  output logic                     empty,
  output logic [a_heigth:0]        count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = 1 << a_heigth;
  localparam logic [a_heigth-1:0] A_ONE = 1;
  localparam logic [a_heigth:0]   C_ONE = 1;
  localparam logic [a_heigth:0]   C_D   = (a_heigth+1)'(PW);

  logic [a_heigth-1:0] wr_addr, rd_addr;

  assign full  = (count == C_D);
  assign empty = (count == '0);

  // rst_n gates the strobes so a held request cannot leak out during reset
  assign write = wr_req & ~full  & rst_n;
  assign read  = rd_req & ~empty & rst_n;

  assign write_pointer = PW'(wr_addr);
  assign read_pointer  = PW'(rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      rd_addr   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write) wr_addr <= wr_addr + A_ONE;
      if (read)  rd_addr <= rd_addr + A_ONE;
      unique case ({write, read})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
      if (wr_req && full)  overflow  <= 1'b1;
      if (rd_req && empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed and randomized check of fifo_ctrl against an occupancy/pointer model.
module tb_fifo_ctrl;
  localparam int AH = 4;
  localparam int D  = 1 << AH;

  logic          clk = 1'b0, rst_n = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic          write, read, full, empty, overflow, underflow;
  logic [D-1:0]  write_pointer, read_pointer;
  logic [AH:0]   count;

  int tests = 0, fails = 0;
  int occ, wp, rp;
  bit ovf, unf;

  fifo_ctrl #(.a_heigth(AH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
    .write(write), .read(read),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ = 0; wp = 0; rp = 0; ovf = 0; unf = 0;
  endtask

  task automatic chk_regs(input string t);
    chk({t, ".count"}, 32'(count), occ);
    chk({t, ".full"},  32'(full),  32'(occ == D));
    chk({t, ".empty"}, 32'(empty), 32'(occ == 0));
    chk({t, ".wp"},    32'(write_pointer), wp);
    chk({t, ".rp"},    32'(read_pointer),  rp);
    chk({t, ".ovf"},   32'(overflow),  32'(ovf));
    chk({t, ".unf"},   32'(underflow), 32'(unf));
  endtask

  // One cycle: drive at negedge, check strobes/addresses, then check post-edge state.
  task automatic step(input bit w, input bit r);
    bit ew, er;
    @(negedge clk);
    wr_req = w; rd_req = r;
    #1;
    ew = w && (occ < D);
    er = r && (occ > 0);
    chk("write", 32'(write), 32'(ew));
    chk("read",  32'(read),  32'(er));
    chk_regs("pre");
    @(posedge clk);
    if (w && occ == D) ovf = 1;
    if (r && occ == 0) unf = 1;
    if (ew) wp = (wp + 1) % D;
    if (er) rp = (rp + 1) % D;
    occ = occ + int'(ew) - int'(er);
    #1;
    chk_regs("post");
  endtask

  // Reset asserted between edges; state must clear with no clock edge.
  task automatic do_reset();
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_regs("rst");
    chk("rst.write", 32'(write), 0);
    chk("rst.read",  32'(read),  0);
    @(posedge clk); #1;
    chk("rst_hold.write", 32'(write), 0);
    chk_regs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    model_reset();
    wr_req = 1'b1; rd_req = 1'b1;
    #3;
    chk_regs("init");
    chk("init.write", 32'(write), 0);
    chk("init.read",  32'(read),  0);
    @(negedge clk);
    rst_n = 1'b1; wr_req = 1'b0; rd_req = 1'b0;

    // three writes from reset
    repeat (3) step(1, 0);
    chk("w3.wp", 32'(write_pointer), 3);
    chk("w3.count", 32'(count), 3);
    chk("w3.empty", 32'(empty), 0);

    // fill to D, then one rejected write
    repeat (D - 3) step(1, 0);
    chk("fill.full", 32'(full), 1);
    chk("fill.wp", 32'(write_pointer), 0);
    step(1, 0);
    chk("ovf.flag", 32'(overflow), 1);
    chk("ovf.count", 32'(count), 16);

    // both requests while full: read wins
    step(1, 1);
    chk("fullboth.count", 32'(count), 15);
    chk("fullboth.full", 32'(full), 0);

    // both requests while empty: write wins
    do_reset();
    step(1, 1);
    chk("emptyboth.count", 32'(count), 1);

    // interleave 20 writes / 20 reads
    do_reset();
    step(1, 0);
    repeat (19) step(1, 1);
    step(0, 1);
    chk("il.wp", 32'(write_pointer), 4);
    chk("il.rp", 32'(read_pointer), 4);
    chk("il.count", 32'(count), 0);
    chk("il.ovf", 32'(overflow), 0);
    chk("il.unf", 32'(underflow), 0);

    // read while empty
    do_reset();
    step(0, 1);
    chk("unf.flag", 32'(underflow), 1);
    chk("unf.rp", 32'(read_pointer), 0);

    // reset mid-operation with count=5; first write afterwards uses address 0
    do_reset();
    repeat (5) step(1, 0);
    chk("mid.count", 32'(count), 5);
    do_reset();
    chk("mid.rst_count", 32'(count), 0);
    step(1, 0);
    chk("mid.wp_after", 32'(write_pointer), 1);

    // randomized traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 600; i++) begin
      bit w, r;
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        if (((i / 50) % 2) == 0) begin
          w = ($urandom_range(0, 3) != 0);
          r = ($urandom_range(0, 3) == 0);
        end else begin
          w = ($urandom_range(0, 3) == 0);
          r = ($urandom_range(0, 3) != 0);
        end
        step(w, r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
